// File: rtl/accel_pkg.sv
// accel_pkg: FSM state encoding and SPI frame constants for accel_spi_sampler.
package accel_pkg;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_CS_HOLD  = 3'd3;
    localparam logic [2:0] S_EMIT     = 3'd4;
    localparam logic READ_BIT  = 1'b1;
    localparam logic MULTI_BIT = 1'b0;
    localparam int FRAME_LEN = 16;
endpackage

// File: rtl/accel_spi_sampler_if.sv
// accel_spi_sampler_if: 4-wire SPI bus between the sampler (master) and the accelerometer (slave).
interface accel_spi_sampler_if;
    logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    modport master(output spi_sclk, spi_cs_n, spi_mosi, input spi_miso);
    modport slave(input spi_sclk, spi_cs_n, spi_mosi, output spi_miso);
endinterface

// File: rtl/sclk_divider.sv
// sclk_divider: half-period counter; start marks the first and done the last cycle of each CLK_DIV-long phase.
module sclk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic run,
    output logic start,
    output logic done
);
    logic [7:0] cnt;
    assign start = run && cnt == 8'd0;
    assign done  = run && cnt == 8'(CLK_DIV - 1);
    always_ff @(posedge sys_clock or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (!run || done) ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/accel_spi_sampler.sv
// accel_spi_sampler: periodic SPI mode-3 read of one accelerometer axis register.
// Define ACCEL_AVG4_EN to emit the floored average of every 4 reads instead of each raw read.
module accel_spi_sampler
    import accel_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int SAMPLE_PERIOD = 1000,
    parameter logic [5:0] REG_ADDR = 6'h32
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic enable,
    accel_spi_sampler_if.master spi,
    output logic o_sync,
    output logic signed [7:0] data,
    output logic busy,
    output logic overrun
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [15:0] FRAME = {READ_BIT, MULTI_BIT, REG_ADDR, 8'h00};
    logic [2:0] state;
    logic [TW-1:0] timer;
    logic tick, run, start, done, hi;
    logic [3:0] bitn;
    logic [7:0] rx;
    assign tick = timer == TW'(SAMPLE_PERIOD - 1);
    assign busy = state != S_IDLE;
    assign overrun = tick && busy;
    assign run = state == S_CS_SETUP || state == S_SHIFT || state == S_CS_HOLD;
    assign spi.spi_cs_n = !run;
    assign spi.spi_sclk = state != S_SHIFT || hi;
    sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .sys_clock(sys_clock),
        .reset(reset),
        .run(run),
        .start(start),
        .done(done)
    );
    always_ff @(posedge sys_clock or negedge reset)
        if (!reset) timer <= '0;
        else timer <= tick ? '0 : timer + 1'b1;
    always_ff @(posedge sys_clock or negedge reset)
        if (!reset) begin
            state <= S_IDLE;
            hi <= 1'b0;
            bitn <= '0;
            rx <= '0;
            spi.spi_mosi <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (tick && enable) state <= S_CS_SETUP;
                S_CS_SETUP:
                    if (done) begin
                        state <= S_SHIFT;
                        hi <= 1'b0;
                        bitn <= '0;
                        spi.spi_mosi <= FRAME[15];
                    end
                S_SHIFT: begin
                    // second byte is the sensor reply; capture on the first high cycle of SCLK
                    if (start && hi && bitn[3]) rx <= {rx[6:0], spi.spi_miso};
                    if (done && !hi) hi <= 1'b1;
                    if (done && hi) begin
                        hi <= 1'b0;
                        if (bitn == 4'(FRAME_LEN - 1)) state <= S_CS_HOLD;
                        else begin
                            bitn <= bitn + 4'd1;
                            spi.spi_mosi <= FRAME[4'd14 - bitn];
                        end
                    end
                end
                S_CS_HOLD: if (done) state <= S_EMIT;
                default: state <= S_IDLE;
            endcase
        end
`ifdef ACCEL_AVG4_EN
    logic signed [9:0] acc, sum;
    logic [1:0] n;
    assign sum = acc + {{2{rx[7]}}, rx};
    always_ff @(posedge sys_clock or negedge reset)
        if (!reset) begin
            o_sync <= 1'b0;
            data <= '0;
            acc <= '0;
            n <= '0;
        end else begin
            o_sync <= state == S_EMIT && n == 2'd3;
            if (state == S_EMIT) begin
                n <= n + 2'd1;
                acc <= n == 2'd3 ? '0 : sum;
                if (n == 2'd3) data <= 8'(sum >>> 2);
            end
        end
`else
    always_ff @(posedge sys_clock or negedge reset)
        if (!reset) begin
            o_sync <= 1'b0;
            data <= '0;
        end else begin
            o_sync <= state == S_EMIT;
            if (state == S_EMIT) data <= rx;
        end
`endif
endmodule

// File: tb/tb_accel_spi_sampler.sv
// tb_accel_spi_sampler: randomized scoreboard bench with a sensor model and a tick-schedule reference.
module tb_accel_spi_sampler;
    localparam int D = 2;
    localparam int P = 40;
    localparam int LAT = 34 * D + 2;
    localparam logic [5:0] RA = 6'h32;
    logic clk = 0, rst_n = 0, enable = 0, o_sync, busy, overrun;
    logic [7:0] data;
    accel_spi_sampler_if spi();
    accel_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(P), .REG_ADDR(RA)) dut (
        .sys_clock(clk),
        .reset(rst_n),
        .enable(enable),
        .spi(spi),
        .o_sync(o_sync),
        .data(data),
        .busy(busy),
        .overrun(overrun)
    );
    always #5 clk = ~clk;

    typedef struct {
        int t;
        logic [7:0] d;
    } exp_t;
    exp_t eq[$];
    logic [7:0] sq[$];
    logic [7:0] fixed[$];
    int cyc, busy_end = -1, acc_sum = 0, acc_n = 0, checks = 0, fails = 0;
    logic [7:0] held = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

    // reference: ticks fall on cycles P-1, 2P-1, ...; an idle enabled tick starts a read
    always @(negedge clk)
        if (rst_n) begin
            automatic bit tk = (cyc % P) == P - 1;
            automatic bit bz = cyc <= busy_end;
            automatic logic [7:0] r;
            chk("busy", busy, bz);
            chk("overrun", overrun, tk && bz);
            if (!bz) chk("cs_n idle", spi.spi_cs_n, 1);
            if (tk && !bz && enable) begin
                r = fixed.size() ? fixed.pop_front() : 8'($urandom);
                sq.push_back(r);
                busy_end = cyc + LAT - 1;
`ifdef ACCEL_AVG4_EN
                acc_sum += int'($signed(r));
                acc_n++;
                if (acc_n == 4) begin
                    eq.push_back('{cyc + LAT, 8'(int'($floor(real'(acc_sum) / 4.0)))});
                    acc_sum = 0;
                    acc_n = 0;
                end
`else
                eq.push_back('{cyc + LAT, r});
`endif
            end
        end

    always @(negedge clk)
        if (rst_n) begin
            if (o_sync) begin
                if (eq.size() == 0) chk("spurious o_sync", o_sync, 0);
                else begin
                    automatic exp_t e = eq.pop_front();
                    chk("o_sync time", cyc, e.t);
                    chk("data", data, e.d);
                    held = e.d;
                end
            end else chk("data hold", data, held);
        end

    int nb;
    logic [7:0] resp;
    logic [15:0] mo;
    always @(negedge spi.spi_cs_n) begin
        resp = sq.size() ? sq.pop_front() : 8'h00;
        nb = 0;
        mo = 0;
    end
    always @(negedge spi.spi_sclk)
        if (!spi.spi_cs_n) begin
            spi.spi_miso = (nb >= 8 && nb < 16) ? resp[15-nb] : 1'($urandom);
            nb++;
        end
    always @(posedge spi.spi_sclk) if (!spi.spi_cs_n) mo = {mo[14:0], spi.spi_mosi};
    always @(posedge spi.spi_cs_n)
        if (rst_n) begin
            chk("sclk bits", nb, 16);
            chk("mosi frame", mo, {2'b10, RA, 8'h00});
        end

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (P / 2) @(posedge clk);
            #1 enable = $urandom_range(0, 2) != 0;
        end
    endtask

    initial begin
        spi.spi_miso = 0;
        fixed = '{8'hC0, 8'hC0, 8'hA0, 8'hA0, 8'h7F};
        repeat (3) @(posedge clk);
        #1;
        chk("rst sclk", spi.spi_sclk, 1);
        chk("rst cs_n", spi.spi_cs_n, 1);
        chk("rst mosi", spi.spi_mosi, 0);
        chk("rst o_sync", o_sync, 0);
        chk("rst data", data, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        rst_n = 1;
        enable = 1;
        repeat (12 * P) @(posedge clk);
        #1 enable = 0;
        repeat (3 * P) @(posedge clk);
        rand_run(40);
        #1 enable = 1;
        for (int i = 0; i < 4 * P && spi.spi_cs_n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cs_n asserted", spi.spi_cs_n, 0);
        repeat (20) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort cs_n", spi.spi_cs_n, 1);
        chk("abort sclk", spi.spi_sclk, 1);
        chk("abort busy", busy, 0);
        eq.delete();
        sq.delete();
        busy_end = -1;
        acc_sum = 0;
        acc_n = 0;
        held = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort data", data, 0);
        chk("abort o_sync", o_sync, 0);
        rst_n = 1;
        rand_run(30);
        #1 enable = 0;
        for (int i = 0; i < 4 * LAT && eq.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("pending strobes", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/accel_spi_sampler.md
ACCEL_SPI_SAMPLER -- requirements
Module: accel_spi_sampler

Interface
REQ-001 The block SHALL expose parameter CLK_DIV, default 2, sys_clock cycles per SCLK half-period (legal 1..255).
REQ-002 The block SHALL expose parameter SAMPLE_PERIOD, default 1000, sys_clock cycles between sample ticks (legal >= 2).
REQ-003 The block SHALL expose parameter REG_ADDR, default 6'h32, the 6-bit accelerometer axis register address to read.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 The port sys_clock SHALL be an input, 1 bit wide: the system clock, rising-edge active.
REQ-006 The port reset SHALL be an input, 1 bit wide: the asynchronous reset, active-low.
REQ-007 The port enable SHALL be an input, 1 bit wide: when high, sample ticks start transactions.
REQ-008 The port spi_miso SHALL be an input, 1 bit wide: serial data from the sensor.
REQ-009 The port spi_sclk SHALL be an output, 1 bit wide: the SPI clock, mode 3 (idles high).
REQ-010 The port spi_cs_n SHALL be an output, 1 bit wide: the active-low chip select.
REQ-011 The port spi_mosi SHALL be an output, 1 bit wide: serial command, MSB first.
REQ-012 The port o_sync SHALL be an output, 1 bit wide: a one-cycle strobe marking new data.
REQ-013 The port data SHALL be an output, 8 bits wide, signed: the sample, stable between strobes.
REQ-014 The port busy SHALL be an output, 1 bit wide: high in every state other than IDLE.
REQ-015 The port overrun SHALL be an output, 1 bit wide: a one-cycle pulse when a tick arrives while busy.

Function
REQ-016 The tick timer SHALL be free-running, wrap at SAMPLE_PERIOD-1 and assert tick for one cycle at wrap, regardless of enable.
REQ-017 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD and EMIT.
REQ-018 IDLE SHALL go to CS_SETUP on (tick AND enable); in IDLE spi_cs_n=1 and spi_sclk=1.
REQ-019 CS_SETUP SHALL drive spi_cs_n=0 and spi_sclk=1 for exactly CLK_DIV cycles.
REQ-020 SHIFT SHALL transfer 16 bits, each occupying CLK_DIV cycles with spi_sclk low followed by CLK_DIV cycles with spi_sclk high.
REQ-021 spi_mosi SHALL change only on entry to an SCLK-low phase; the 8 command bits SHALL be {1 (read), 0 (single), REG_ADDR}, then 0 for the remaining 8 bits.
REQ-022 spi_miso SHALL be sampled in the sys_clock cycle in which spi_sclk goes high, for bits 9..16 only, MSB first.
REQ-023 CS_HOLD SHALL keep spi_cs_n=0 and spi_sclk=1 for CLK_DIV cycles, then go to EMIT with spi_cs_n=1.
REQ-024 EMIT SHALL last one cycle, register data and assert o_sync, then return to IDLE.
REQ-025 o_sync SHALL rise exactly 34*CLK_DIV+2 cycles after the tick cycle that started the transaction.
REQ-026 A tick while busy SHALL be dropped, SHALL not queue, and SHALL pulse overrun in that same cycle; a tick while enable=0 in IDLE SHALL be ignored silently.
REQ-027 Deasserting enable mid-transaction SHALL NOT abort the transaction.

Reset
REQ-028 While reset=0: FSM=IDLE, timer=0, spi_sclk=1, spi_cs_n=1, spi_mosi=0, o_sync=0, data=8'h00, busy=0, overrun=0, and the average accumulator cleared.
REQ-029 Reset mid-transaction SHALL immediately release spi_cs_n with no o_sync; the first tick after release SHALL occur SAMPLE_PERIOD cycles later.

Configuration
REQ-030 With macro ACCEL_AVG4_EN defined, data SHALL be the floor of (sum of 4 consecutive reads)/4: a 10-bit signed sum, arithmetic shift right by 2, o_sync on every 4th EMIT only.
REQ-031 Without ACCEL_AVG4_EN, every EMIT SHALL output the raw read byte with o_sync.

Structure
REQ-032 Package accel_pkg SHALL hold the FSM state encoding, the READ_BIT/MULTI_BIT constants and the 16-bit frame length constant.
REQ-033 SCLK phase timing SHALL live in sub-module sclk_divider (half-period counter, phase-edge strobes).

Verification (CLK_DIV=2, SAMPLE_PERIOD=100, REG_ADDR=6'h32)
REQ-034 Single read: the sensor model returns 8'hC0 -> MOSI command 8'hB2, data=8'hC0, one o_sync pulse 70 cycles after the tick.
REQ-035 Sign handling: returns 8'hA0 then 8'h7F -> data -96 then +127, two strobes exactly 100 cycles apart.
REQ-036 Overrun: SAMPLE_PERIOD=40 -> each transaction spans 68 cycles, alternate ticks pulse overrun, and no o_sync is lost or duplicated.
REQ-037 Reset mid-SHIFT (bit 5): spi_cs_n goes to 1 asynchronously, no o_sync occurs, and data holds 8'h00.
REQ-038 ACCEL_AVG4_EN: reads C0, C0, A0, A0 -> a single o_sync with data=8'hB0 (-80).
REQ-039 Enable low: ticks occur with spi_cs_n held at 1 and no overrun pulse.
